// File: rtl/d_reg_serial_tx.sv
// Frames a parallel word onto SOUT: start(0), data LSB first, optional even parity, stop(1).
// Start bit follows accept by one cycle; DIN_READY is low for the whole frame. The parity bit is enabled by defining D_REG_SERIAL_TX_PARITY_EN.
module d_reg_serial_tx #(
    parameter int WIDTH    = 4,
    parameter int BIT_CLKS = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             SOUT,
    output logic             BUSY,
    output logic             DONE
);
    localparam int PW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(BIT_CLKS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [PW-1:0]    per_q, per_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             sout_d, busy_d, done_d;
    logic             accept, per_end, par_bit;

`ifdef D_REG_SERIAL_TX_PARITY_EN
    logic par_q, par_d;
    assign par_bit = par_q;
`else
    assign par_bit = 1'b0;
`endif

    assign DIN_READY = RST_N & (state_q == S_IDLE);
    assign accept    = DIN_VALID & DIN_READY;
    assign per_end   = (per_q == PER_LAST);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        per_d   = per_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        sout_d  = 1'b1;
        busy_d  = 1'b0;
`ifdef D_REG_SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q == S_IDLE)
            per_d = '0;
        else
            per_d = per_end ? '0 : per_q + PW'(1);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    shift_d = DIN;
`ifdef D_REG_SERIAL_TX_PARITY_EN
                    par_d   = ^DIN;
`endif
                end
            end
            S_START: begin
                if (per_end)
                    state_d = S_DATA;
            end
            S_DATA: begin
                if (per_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef D_REG_SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (per_end)
                    state_d = S_STOP;
            end
            S_STOP: begin
                if (per_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are derived from the next state so the registered copies line up with state_q.
        case (state_d)
            S_START:  sout_d = 1'b0;
            S_DATA:   sout_d = shift_d[0];
            S_PARITY: sout_d = par_bit;
            default:  sout_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            per_q   <= '0;
            bit_q   <= '0;
            SOUT    <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
`ifdef D_REG_SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            per_q   <= per_d;
            bit_q   <= bit_d;
            SOUT    <= sout_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
`ifdef D_REG_SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_d_reg_serial_tx.sv
// Directed bench for d_reg_serial_tx: WIDTH=4 with BIT_CLKS=2 and BIT_CLKS=1 instances.
module tb_d_reg_serial_tx;
    localparam int BC = 2;
`ifdef D_REG_SERIAL_TX_PARITY_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] DIN;
    logic       DIN_VALID;
    logic       DIN_READY, SOUT, BUSY, DONE;
    logic [3:0] d1;
    logic       v1;
    logic       rdy1, s1, b1, dn1;

    always #5 CLK = ~CLK;

    d_reg_serial_tx #(.WIDTH(4), .BIT_CLKS(BC)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .DIN_READY(DIN_READY), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE)
    );

    d_reg_serial_tx #(.WIDTH(4), .BIT_CLKS(1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .DIN(d1), .DIN_VALID(v1),
        .DIN_READY(rdy1), .SOUT(s1), .BUSY(b1), .DONE(dn1)
    );

    // Frame bit i is the i-th bit sent: start, d0..d3, [parity], stop.
    typedef struct {
        logic [3:0] din;
        logic [7:0] frame;
    } vec_t;

    vec_t vec [5];
    logic [7:0] f_a, f_5, f_3, f_0;
    int n_chk  = 0;
    int n_pass = 0;
    int done_seen;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic send(input logic [3:0] d, input logic [7:0] fr,
                        input logic [3:0] nd, input logic nv, input string tag);
        DIN = d;
        DIN_VALID = 1'b1;
        chk({tag, "_ready_idle"}, DIN_READY, 1'b1);
        @(posedge CLK); #1;
        DIN = nd;
        DIN_VALID = nv;
        for (int c = 0; c < NB * BC; c++) begin
            @(negedge CLK);
            chk($sformatf("%s_sout_c%0d", tag, c), SOUT, fr[c / BC]);
            chk($sformatf("%s_busy_c%0d", tag, c), BUSY, 1'b1);
            chk($sformatf("%s_ready_c%0d", tag, c), DIN_READY, 1'b0);
            chk($sformatf("%s_done_c%0d", tag, c), DONE, 1'b0);
        end
        @(negedge CLK);
        chk({tag, "_done_pulse"}, DONE, 1'b1);
        chk({tag, "_busy_end"}, BUSY, 1'b0);
        chk({tag, "_sout_end"}, SOUT, 1'b1);
        chk({tag, "_ready_done"}, DIN_READY, 1'b1);
    endtask

    initial begin
`ifdef D_REG_SERIAL_TX_PARITY_EN
        vec[0] = '{4'hB, 8'b0111_0110};
        vec[1] = '{4'hA, 8'b0101_0100};
        vec[2] = '{4'h5, 8'b0100_1010};
        vec[3] = '{4'hF, 8'b0101_1110};
        vec[4] = '{4'h0, 8'b0100_0000};
        f_3    = 8'b0100_0110;
`else
        vec[0] = '{4'hB, 8'b0011_0110};
        vec[1] = '{4'hA, 8'b0011_0100};
        vec[2] = '{4'h5, 8'b0010_1010};
        vec[3] = '{4'hF, 8'b0011_1110};
        vec[4] = '{4'h0, 8'b0010_0000};
        f_3    = 8'b0010_0110;
`endif
        f_a = vec[1].frame;
        f_5 = vec[2].frame;
        f_0 = vec[4].frame;

        RST_N = 1'b0; DIN = '0; DIN_VALID = 1'b0; d1 = '0; v1 = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst_sout", SOUT, 1'b1);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_ready_low", DIN_READY, 1'b0);
        chk("rst_sout_bc1", s1, 1'b1);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", DIN_READY, 1'b1);
        chk("post_rst_busy", BUSY, 1'b0);
        @(posedge CLK); #1;

        for (int i = 0; i < 5; i++) begin
            send(vec[i].din, vec[i].frame, 4'h0, 1'b0, $sformatf("vec%0d", i));
            @(posedge CLK); #1;
            @(negedge CLK);
            chk($sformatf("vec%0d_done_once", i), DONE, 1'b0);
            chk($sformatf("vec%0d_idle_sout", i), SOUT, 1'b1);
            @(posedge CLK); #1;
        end

        // DIN changes right after accept; captured word must still go out.
        send(4'h3, f_3, 4'hF, 1'b0, "din_change");
        @(posedge CLK); #1;
        @(posedge CLK); #1;

        // Back-to-back with DIN_VALID held; second accept happens in the DONE cycle.
        send(4'hA, f_a, 4'h5, 1'b1, "b2b_a");
        send(4'h5, f_5, 4'h0, 1'b0, "b2b_5");
        @(posedge CLK); #1;
        @(posedge CLK); #1;

        // Reset during data bit 2 abandons the frame without a DONE pulse.
        DIN = 4'hB; DIN_VALID = 1'b1;
        @(posedge CLK); #1;
        DIN_VALID = 1'b0;
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        chk("abort_pre_sout", SOUT, 1'b0);
        chk("abort_pre_busy", BUSY, 1'b1);
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("abort_sout", SOUT, 1'b1);
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_done", DONE, 1'b0);
        chk("abort_ready", DIN_READY, 1'b1);
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (DONE) done_seen++;
        end
        chk("abort_no_done", done_seen == 0, 1'b1);
        @(posedge CLK); #1;

        // BIT_CLKS=1: one cycle per bit.
        d1 = 4'h0; v1 = 1'b1;
        @(negedge CLK);
        chk("bc1_ready", rdy1, 1'b1);
        @(posedge CLK); #1;
        v1 = 1'b0;
        for (int c = 0; c < NB; c++) begin
            @(negedge CLK);
            chk($sformatf("bc1_sout_c%0d", c), s1, f_0[c]);
            chk($sformatf("bc1_busy_c%0d", c), b1, 1'b1);
        end
        @(negedge CLK);
        chk("bc1_done", dn1, 1'b1);
        chk("bc1_idle_sout", s1, 1'b1);
        @(negedge CLK);
        chk("bc1_done_clear", dn1, 1'b0);
        chk("bc1_idle_sout2", s1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
